// File: rtl/zmod_pkg.sv
// Shared types and constants for the ZMOD receive word aligner.
package zmod_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        CHECK     = 3'd2,
        SLIP      = 3'd3,
        WAIT_SLIP = 3'd4,
        ALIGNED   = 3'd5,
        FAIL      = 3'd6
    } align_state_e;

    localparam logic [7:0] ZMOD_TRAIN_PATTERN = 8'h0F;

endpackage

// File: rtl/zmod_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module zmod_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // meta_q may go metastable; only sync_q is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/zmod_rx_word_align.sv
// ISERDES word aligner: bitslips until the training word is seen MATCH_COUNT
// times in a row, then flags lock and qualifies the registered data stream.
module zmod_rx_word_align
    import zmod_pkg::*;
#(
    parameter int                 DATA_W        = 8,
    parameter logic [DATA_W-1:0]  TRAIN_PATTERN = DATA_W'(ZMOD_TRAIN_PATTERN),
    parameter int                 MATCH_COUNT   = 16,
    parameter int                 SETTLE_CYCLES = 32,
    parameter int                 SLIP_WAIT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmcm_locked,
    input  logic              retrain,
    input  logic [DATA_W-1:0] rx_data,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_error,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_valid
);

    localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int SLIP_W   = $clog2(DATA_W);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WAIT_W   = $clog2(SLIP_WAIT + 1);

    logic lock_s;

    align_state_e        state_q, state_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bitslip_q, bitslip_d;
    logic                aligned_q, aligned_d;
    logic                align_error_q, align_error_d;
    logic [DATA_W-1:0]   rx_data_q;

    zmod_sync2 #(.W(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (mmcm_locked),
        .q_o (lock_s)
    );

    // Lock loss outranks retrain, which outranks every normal transition
    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        if (!lock_s) begin
            state_d      = WAIT_LOCK;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            settle_cnt_d = '0;
            wait_cnt_d   = '0;
        end else if (retrain && (state_q != WAIT_LOCK)) begin
            state_d      = SETTLE;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            settle_cnt_d = '0;
            wait_cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d      = SETTLE;
                    match_cnt_d  = '0;
                    slip_cnt_d   = '0;
                    settle_cnt_d = '0;
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d      = CHECK;
                        settle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
                CHECK: begin
                    if (rx_data == TRAIN_PATTERN) begin
                        if (match_cnt_q == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_d = ALIGNED;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q < SLIP_W'(DATA_W - 1)) begin
                            state_d = SLIP;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                SLIP: begin
                    slip_cnt_d = slip_cnt_q + SLIP_W'(1);
                    wait_cnt_d = '0;
                    state_d    = WAIT_SLIP;
                end
                WAIT_SLIP: begin
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_d    = CHECK;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                ALIGNED: state_d = ALIGNED;
                FAIL:    state_d = FAIL;
                default: state_d = WAIT_LOCK;
            endcase
        end
        bitslip_d     = (state_d == SLIP);
        aligned_d     = (state_q == ALIGNED) && (state_d == ALIGNED);
        align_error_d = (state_q == FAIL) && (state_d == FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            match_cnt_q   <= '0;
            slip_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            bitslip_q     <= 1'b0;
            aligned_q     <= 1'b0;
            align_error_q <= 1'b0;
            rx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            match_cnt_q   <= match_cnt_d;
            slip_cnt_q    <= slip_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            bitslip_q     <= bitslip_d;
            aligned_q     <= aligned_d;
            align_error_q <= align_error_d;
            rx_data_q     <= rx_data;
        end
    end

    assign bitslip     = bitslip_q;
    assign aligned     = aligned_q;
    assign rx_valid    = aligned_q;
    assign align_error = align_error_q;
    assign rx_data_out = rx_data_q;

endmodule

// File: tb/tb_zmod_rx_word_align.sv
// Directed bench for zmod_rx_word_align with a simple rotating ISERDES model.
module tb_zmod_rx_word_align;

    logic       clk;
    logic       rst;
    logic       mmcm_locked;
    logic       retrain;
    logic [7:0] rx_data;
    logic       bitslip;
    logic       aligned;
    logic       align_error;
    logic [7:0] rx_data_out;
    logic       rx_valid;

    int nvec     = 0;
    int nerr     = 0;
    int bs_count = 0;
    bit prev_bs  = 1'b0;
    bit rot_mode = 1'b0;
    int phase    = 0;

    zmod_rx_word_align dut (
        .clk         (clk),
        .rst         (rst),
        .mmcm_locked (mmcm_locked),
        .retrain     (retrain),
        .rx_data     (rx_data),
        .bitslip     (bitslip),
        .aligned     (aligned),
        .align_error (align_error),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the ISERDES model rotates back one phase per bitslip pulse
    task automatic step();
        @(posedge clk);
        #1;
        if (bitslip) begin
            chk("bitslip_not_back_to_back", 32'(prev_bs), 32'd0);
            bs_count++;
            if (rot_mode && phase > 0) phase--;
        end
        prev_bs = bitslip;
        if (rot_mode) rx_data = rotl(8'h0F, phase);
    endtask

    task automatic run_until(input bit want_err, input int budget, output int cyc,
                             output int slips, output int min_gap, output bit hit,
                             output bit saw_aligned);
        int last;
        int start;
        last        = -1000;
        start       = bs_count;
        cyc         = 0;
        min_gap     = 1000;
        hit         = 1'b0;
        saw_aligned = 1'b0;
        while (!hit && cyc < budget) begin
            step();
            cyc++;
            if (bitslip) begin
                if (cyc - last < min_gap) min_gap = cyc - last;
                last = cyc;
            end
            if (aligned) saw_aligned = 1'b1;
            hit = want_err ? align_error : aligned;
        end
        slips = bs_count - start;
    endtask

    initial begin
        int cyc;
        int slips;
        int gap;
        int base;
        bit hit;
        bit sa;

        rst         = 1'b1;
        mmcm_locked = 1'b0;
        retrain     = 1'b0;
        rx_data     = 8'h0F;
        #20;
        chk("rst_bitslip", 32'(bitslip), 32'd0);
        chk("rst_aligned", 32'(aligned), 32'd0);
        chk("rst_align_error", 32'(align_error), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data_out", 32'(rx_data_out), 32'd0);

        // Clean pattern: 2 sync + 1 + 32 settle + 16 matches + 1 output register
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mmcm_locked = 1'b1;
        base        = bs_count;
        repeat (51) step();
        chk("clean_aligned_early", 32'(aligned), 32'd0);
        step();
        chk("clean_aligned", 32'(aligned), 32'd1);
        chk("clean_rx_valid", 32'(rx_valid), 32'd1);
        chk("clean_align_error", 32'(align_error), 32'd0);
        chk("clean_no_slip", 32'(bs_count - base), 32'd0);

        rx_data = 8'h5A;
        step();
        chk("data_out_5a", 32'(rx_data_out), 32'h5A);
        chk("aligned_ignores_data", 32'(aligned), 32'd1);
        rx_data = 8'h0F;

        // Lock loss while aligned, then a full relock
        mmcm_locked = 1'b0;
        repeat (3) step();
        chk("lockloss_aligned", 32'(aligned), 32'd0);
        chk("lockloss_rx_valid", 32'(rx_valid), 32'd0);
        mmcm_locked = 1'b1;
        run_until(1'b0, 200, cyc, slips, gap, hit, sa);
        chk("relock_hit", 32'(hit), 32'd1);
        chk("relock_cycles", 32'(cyc), 32'd52);
        chk("relock_slips", 32'(slips), 32'd0);

        // Rotated by 3 phases
        rot_mode = 1'b1;
        phase    = 3;
        rx_data  = rotl(8'h0F, 3);
        retrain  = 1'b1;
        step();
        retrain = 1'b0;
        chk("retrain_clears_aligned", 32'(aligned), 32'd0);
        chk("retrain_clears_valid", 32'(rx_valid), 32'd0);
        run_until(1'b0, 600, cyc, slips, gap, hit, sa);
        chk("rot3_hit", 32'(hit), 32'd1);
        chk("rot3_slips", 32'(slips), 32'd3);
        chk("rot3_gap_ge5", 32'(gap >= 5), 32'd1);

        // Ten matches, one bad word, then clean again
        rot_mode = 1'b0;
        rx_data  = 8'h0F;
        retrain  = 1'b1;
        step();
        retrain = 1'b0;
        base    = bs_count;
        repeat (42) step();
        chk("m10_no_slip_yet", 32'(bs_count - base), 32'd0);
        rx_data = 8'h1E;
        step();
        chk("m10_bitslip", 32'(bitslip), 32'd1);
        rx_data = 8'h0F;
        base    = bs_count;
        repeat (16) step();
        chk("m10_count_restarted", 32'(aligned), 32'd0);
        repeat (6) step();
        chk("m10_aligned", 32'(aligned), 32'd1);
        chk("m10_single_slip", 32'(bs_count - base), 32'd0);

        // Never-matching data: exhaust all phases
        rx_data = 8'hAA;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        run_until(1'b1, 400, cyc, slips, gap, hit, sa);
        chk("aa_fail_hit", 32'(hit), 32'd1);
        chk("aa_slips", 32'(slips), 32'd7);
        chk("aa_never_aligned", 32'(sa), 32'd0);
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        chk("aa_retrain_clears_err", 32'(align_error), 32'd0);
        run_until(1'b1, 400, cyc, slips, gap, hit, sa);
        chk("aa2_fail_hit", 32'(hit), 32'd1);
        chk("aa2_slips", 32'(slips), 32'd7);

        // Async reset in the middle of WAIT_SLIP
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        cyc     = 0;
        while (!bitslip && cyc < 100) begin
            step();
            cyc++;
        end
        chk("wslip_slip_seen", 32'(bitslip), 32'd1);
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bitslip", 32'(bitslip), 32'd0);
        chk("arst_aligned", 32'(aligned), 32'd0);
        chk("arst_align_error", 32'(align_error), 32'd0);
        chk("arst_rx_valid", 32'(rx_valid), 32'd0);
        chk("arst_rx_data_out", 32'(rx_data_out), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rx_data = 8'h0F;
        prev_bs = 1'b0;
        run_until(1'b0, 200, cyc, slips, gap, hit, sa);
        chk("arst_restart_hit", 32'(hit), 32'd1);
        chk("arst_restart_cycles", 32'(cyc), 32'd52);
        chk("arst_restart_slips", 32'(slips), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
